// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS increment slew controller.
package dds_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DWELL,
    STEP,
    SETTLE,
    RELOCK
  } state_e;

  localparam logic [31:0] DDS_DEFAULT_INCREMENT = 32'h3333_3333;
  localparam int          STEP_COUNT_WIDTH      = 16;
  localparam logic [STEP_COUNT_WIDTH-1:0] STEP_COUNT_MAX = '1;

endpackage

// File: rtl/lock_qualifier.sv
// Synchronises an asynchronous PLL lock flag and qualifies it as stable only
// after LOCK_STABLE_CYCLES consecutive synchronised-high cycles.
module lock_qualifier #(
  parameter int LOCK_STABLE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_in,
  input  logic i_async_locked,
  output logic o_synced_locked,
  output logic o_locked_q
);

  localparam int                CNT_W   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_STABLE_CYCLES);

  logic             r_sync_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_stable_cnt;
  logic             r_locked_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which keeps the two synchroniser stages distinct.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_sync_meta  <= 1'b0;
      r_sync       <= 1'b0;
      r_stable_cnt <= '0;
      r_locked_q   <= 1'b0;
    end else begin
      r_sync_meta <= i_async_locked;
      r_sync      <= r_sync_meta;
      if (!r_sync) begin
        r_stable_cnt <= '0;
        r_locked_q   <= 1'b0;
      end else if (r_stable_cnt != CNT_MAX) begin
        r_stable_cnt <= r_stable_cnt + CNT_W'(1);
        r_locked_q   <= (r_stable_cnt == CNT_MAX - CNT_W'(1));
      end else begin
        r_locked_q <= 1'b1;
      end
    end
  end

  assign o_synced_locked = r_sync;
  assign o_locked_q      = r_locked_q;

endmodule

// File: rtl/dds_slew_controller.sv
// Walks the DDS phase increment toward a requested target in bounded steps,
// dwelling between steps and pausing while the downstream PLL chain relocks.
module dds_slew_controller
  import dds_ctrl_pkg::*;
#(
  parameter int                   INC_WIDTH          = 32,
  parameter int                   DWELL_WIDTH        = 16,
  parameter logic [INC_WIDTH-1:0] DEFAULT_INCREMENT  = INC_WIDTH'(DDS_DEFAULT_INCREMENT),
  parameter int                   LOCK_STABLE_CYCLES = 1024
) (
  input  logic                        clk_ref,
  input  logic                        reset_in,
  input  logic [INC_WIDTH-1:0]        target_increment,
  input  logic [INC_WIDTH-1:0]        max_step,
  input  logic [DWELL_WIDTH-1:0]      dwell_cycles,
  input  logic                        go,
  input  logic                        abort,
  input  logic                        pll_locked,
  output logic [INC_WIDTH-1:0]        increment,
  output logic                        busy,
  output logic                        done,
  output logic                        lock_lost,
  output logic [STEP_COUNT_WIDTH-1:0] step_count
);

  state_e                      r_state,       w_state_next;
  logic [INC_WIDTH-1:0]        r_increment,   w_increment_next;
  logic [INC_WIDTH-1:0]        r_target,      w_target_next;
  logic [INC_WIDTH-1:0]        r_max_step,    w_max_step_next;
  logic [DWELL_WIDTH-1:0]      r_dwell,       w_dwell_next;
  logic [DWELL_WIDTH-1:0]      r_dwell_cnt,   w_dwell_cnt_next;
  logic [STEP_COUNT_WIDTH-1:0] r_step_count,  w_step_count_next;
  logic                        r_done,        w_done_next;
  logic                        r_lock_lost,   w_lock_lost_next;
  logic                        r_busy;

  logic                        w_sync_locked;
  logic                        w_locked_q;
  logic                        w_step_up;
  logic [INC_WIDTH-1:0]        w_dist;
  logic                        w_final_step;
  logic [INC_WIDTH-1:0]        w_step_value;

  lock_qualifier #(
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_qualifier (
    .clk            (clk_ref),
    .reset_in       (reset_in),
    .i_async_locked (pll_locked),
    .o_synced_locked(w_sync_locked),
    .o_locked_q     (w_locked_q)
  );

  // Direction comes from an unsigned compare and the last step clamps to the
  // target, so the increment never wraps or overshoots.
  assign w_step_up    = (r_target > r_increment);
  assign w_dist       = w_step_up ? (r_target - r_increment) : (r_increment - r_target);
  assign w_final_step = (r_max_step == '0) || (w_dist <= r_max_step);
  assign w_step_value = w_final_step ? r_target
                      : (w_step_up ? (r_increment + r_max_step) : (r_increment - r_max_step));

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch can be inferred.
  always_comb begin
    w_state_next      = r_state;
    w_increment_next  = r_increment;
    w_target_next     = r_target;
    w_max_step_next   = r_max_step;
    w_dwell_next      = r_dwell;
    w_dwell_cnt_next  = r_dwell_cnt;
    w_step_count_next = r_step_count;
    w_lock_lost_next  = r_lock_lost;
    w_done_next       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (go && !abort) begin
          w_target_next     = target_increment;
          w_max_step_next   = max_step;
          w_dwell_next      = dwell_cycles;
          w_lock_lost_next  = 1'b0;
          w_step_count_next = '0;
          if (target_increment == r_increment) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next     = DWELL;
            w_dwell_cnt_next = dwell_cycles;
          end
        end
      end

      DWELL: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (!w_sync_locked) begin
          w_state_next     = RELOCK;
          w_lock_lost_next = 1'b1;
        end else if (r_dwell_cnt == '0) begin
          w_state_next = STEP;
        end else begin
          w_dwell_cnt_next = r_dwell_cnt - DWELL_WIDTH'(1);
        end
      end

      STEP: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (!w_sync_locked) begin
          w_state_next     = RELOCK;
          w_lock_lost_next = 1'b1;
        end else begin
          w_increment_next = w_step_value;
          if (r_step_count != STEP_COUNT_MAX) begin
            w_step_count_next = r_step_count + STEP_COUNT_WIDTH'(1);
          end
          if (w_final_step) begin
            w_state_next = SETTLE;
          end else begin
            w_state_next     = DWELL;
            w_dwell_cnt_next = r_dwell;
          end
        end
      end

      SETTLE: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_locked_q) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end

      RELOCK: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_locked_q) begin
          w_state_next     = DWELL;
          w_dwell_cnt_next = r_dwell;
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (reset_in) begin
      r_state      <= IDLE;
      r_increment  <= DEFAULT_INCREMENT;
      r_target     <= DEFAULT_INCREMENT;
      r_max_step   <= '0;
      r_dwell      <= '0;
      r_dwell_cnt  <= '0;
      r_step_count <= '0;
      r_done       <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_increment  <= w_increment_next;
      r_target     <= w_target_next;
      r_max_step   <= w_max_step_next;
      r_dwell      <= w_dwell_next;
      r_dwell_cnt  <= w_dwell_cnt_next;
      r_step_count <= w_step_count_next;
      r_done       <= w_done_next;
      r_lock_lost  <= w_lock_lost_next;
      r_busy       <= (w_state_next != IDLE);
    end
  end

  assign increment  = r_increment;
  assign busy       = r_busy;
  assign done       = r_done;
  assign lock_lost  = r_lock_lost;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_dds_slew_controller.sv
// Self-checking bench for dds_slew_controller: expected increments are queued
// when a slew is launched and popped as the DUT's increment changes.
module tb_dds_slew_controller;

  localparam int INC_W   = 32;
  localparam int DWELL_W = 16;
  localparam logic [31:0] DEF_INC = 32'h3333_3333;

  logic               clk_ref = 1'b0;
  logic               reset_in;
  logic [INC_W-1:0]   target_increment;
  logic [INC_W-1:0]   max_step;
  logic [DWELL_W-1:0] dwell_cycles;
  logic               go;
  logic               abort;
  logic               pll_locked;
  logic [INC_W-1:0]   increment;
  logic               busy;
  logic               done;
  logic               lock_lost;
  logic [15:0]        step_count;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  int          chg_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          go_cyc = 0;
  int          relock_cyc = 0;
  bit          busy_seen = 1'b0;
  bit          mon_en = 1'b0;
  logic [31:0] prev_inc;
  logic [31:0] pop_val;

  always #5 clk_ref = ~clk_ref;

  dds_slew_controller #(
    .INC_WIDTH         (INC_W),
    .DWELL_WIDTH       (DWELL_W),
    .DEFAULT_INCREMENT (DEF_INC),
    .LOCK_STABLE_CYCLES(16)
  ) dut (
    .clk_ref         (clk_ref),
    .reset_in        (reset_in),
    .target_increment(target_increment),
    .max_step        (max_step),
    .dwell_cycles    (dwell_cycles),
    .go              (go),
    .abort           (abort),
    .pll_locked      (pll_locked),
    .increment       (increment),
    .busy            (busy),
    .done            (done),
    .lock_lost       (lock_lost),
    .step_count      (step_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every increment change must match the queue head.
  always @(posedge clk_ref) begin
    cyc++;
    #1;
    if (mon_en && (increment !== prev_inc)) begin
      if (exp_q.size() == 0) begin
        check("inc_unexpected", increment, prev_inc);
      end else begin
        pop_val = exp_q.pop_front();
        check("inc_step", increment, pop_val);
      end
      chg_cyc.push_back(cyc);
    end
    prev_inc = increment;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_ref);
      #2;
    end
  endtask

  task automatic clear_obs();
    chg_cyc.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic start_go(input logic [31:0] tgt, input logic [31:0] mstep, input logic [15:0] dwell);
    target_increment = tgt;
    max_step         = mstep;
    dwell_cycles     = dwell;
    go               = 1'b1;
    tick();
    go_cyc = cyc;
    go     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, done_cnt, 1);
  endtask

  task automatic wait_chg(input string tag, input int cnt, input int budget);
    int n = 0;
    while (chg_cyc.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    check(tag, chg_cyc.size(), cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in         = 1'b1;
    go               = 1'b0;
    abort            = 1'b0;
    pll_locked       = 1'b1;
    target_increment = '0;
    max_step         = '0;
    dwell_cycles     = '0;

    // Reset state
    tick(3);
    check("rst_inc",       increment,  DEF_INC);
    check("rst_busy",      busy,       0);
    check("rst_done",      done,       0);
    check("rst_lock_lost", lock_lost,  0);
    check("rst_steps",     step_count, 0);
    reset_in = 1'b0;
    mon_en   = 1'b1;
    tick(30);

    // Up-slew in 0x40 steps, dwell 3
    clear_obs();
    exp_q.push_back(32'h3333_3373);
    exp_q.push_back(32'h3333_33B3);
    exp_q.push_back(32'h3333_33F3);
    exp_q.push_back(32'h3333_3400);
    start_go(32'h3333_3400, 32'h40, 16'd3);
    check("up_busy_c1", busy, 1);
    wait_done("up_done", 200);
    tick(3);
    check("up_q_empty", exp_q.size(), 0);
    check("up_steps",   step_count,   4);
    check("up_done_n",  done_cnt,     1);
    check("up_busy_end", busy,        0);
    check("up_inc_end", increment,    32'h3333_3400);
    check("up_chg_n",   chg_cyc.size(), 4);
    if (chg_cyc.size() == 4) begin
      check("up_first_lat", chg_cyc[0] - go_cyc, 5);
      for (int i = 1; i < 4; i++) check("up_spacing", chg_cyc[i] - chg_cyc[i-1], 5);
      check("up_done_lat", done_cyc - chg_cyc[3], 1);
    end

    // Down-slew as a single jump
    clear_obs();
    exp_q.push_back(32'h3333_3000);
    start_go(32'h3333_3000, 32'h0, 16'd0);
    wait_done("dn_done", 100);
    tick(3);
    check("dn_q_empty", exp_q.size(), 0);
    check("dn_steps",   step_count,   1);
    check("dn_done_n",  done_cnt,     1);
    check("dn_inc",     increment,    32'h3333_3000);

    // Reset in the middle of a dwell
    clear_obs();
    start_go(32'h3333_4000, 32'h10, 16'd20);
    tick(5);
    check("mid_busy_pre", busy, 1);
    exp_q.push_back(DEF_INC);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("mid_rst_inc",   increment,  DEF_INC);
    check("mid_rst_busy",  busy,       0);
    check("mid_rst_lost",  lock_lost,  0);
    check("mid_rst_steps", step_count, 0);
    check("mid_q_empty",   exp_q.size(), 0);
    tick(30);

    // Abort after the second step; a go while busy is ignored
    clear_obs();
    exp_q.push_back(32'h3333_3373);
    exp_q.push_back(32'h3333_33B3);
    start_go(32'h3333_3400, 32'h40, 16'd3);
    wait_chg("ab_chg1", 1, 50);
    start_go(32'h3333_3000, 32'h0, 16'd0);
    check("ab_go_busy_ignored", busy, 1);
    wait_chg("ab_chg2", 2, 50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_inc",  increment, 32'h3333_33B3);
    tick(20);
    check("ab_inc_held", increment, 32'h3333_33B3);
    check("ab_no_done",  done_cnt,  0);
    check("ab_steps",    step_count, 2);
    check("ab_q_empty",  exp_q.size(), 0);

    // go together with abort in IDLE does nothing
    clear_obs();
    abort = 1'b1;
    start_go(32'h3333_3000, 32'h0, 16'd0);
    abort = 1'b0;
    tick(10);
    check("ga_busy_seen", busy_seen, 0);
    check("ga_done",      done_cnt,  0);
    check("ga_steps",     step_count, 2);
    check("ga_inc",       increment, 32'h3333_33B3);

    // Lock loss mid-slew: freeze, sticky flag, resume after requalification
    clear_obs();
    exp_q.push_back(32'h3333_33F3);
    exp_q.push_back(32'h3333_3400);
    start_go(32'h3333_3400, 32'h40, 16'd8);
    check("ll_steps_clr", step_count, 0);
    check("ll_busy",      busy,       1);
    wait_chg("ll_chg1", 1, 50);
    pll_locked = 1'b0;
    tick(4);
    pll_locked = 1'b1;
    relock_cyc = cyc;
    tick(2);
    check("ll_lost",   lock_lost, 1);
    check("ll_busy2",  busy,      1);
    check("ll_frozen", increment, 32'h3333_33F3);
    check("ll_chg_n",  chg_cyc.size(), 1);
    wait_done("ll_done", 300);
    tick(3);
    check("ll_inc_end",  increment,    32'h3333_3400);
    check("ll_q_empty",  exp_q.size(), 0);
    check("ll_sticky",   lock_lost,    1);
    check("ll_steps",    step_count,   2);
    check("ll_done_n",   done_cnt,     1);
    if (chg_cyc.size() == 2) check("ll_relock_delay", (chg_cyc[1] - relock_cyc) >= 25, 1);

    // go with target equal to current increment
    clear_obs();
    start_go(32'h3333_3400, 32'h40, 16'd3);
    check("eq_done_c1", done, 1);
    check("eq_busy_c1", busy, 0);
    tick();
    check("eq_done_c2", done, 0);
    tick(3);
    check("eq_busy_seen", busy_seen,  0);
    check("eq_done_n",    done_cnt,   1);
    check("eq_lost_clr",  lock_lost,  0);
    check("eq_steps",     step_count, 0);
    check("eq_q_empty",   exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
